spi_reg_sequencer: RTL and testbench

//  System-clock controller for spi_slave. Decodes each ss-framed SPI transaction as a command byte plus data bytes.

---
 rtl/spi_reg_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - byte-level command sequencer and register file behind spi_slave
//
// Purpose: runs in the clk domain and decodes each ss-framed SPI transaction.
//   The first byte is a command: bit 7 = write, bits [ADDR_W-1:0] = start address,
//   and bits [6:ADDR_W] must be zero. The following bytes are either written to
//   consecutive registers or used to clock back consecutive register contents.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ss_n, spi_done  raw pin / spi_slave inputs, synchronized internally
//   spi_rdata       byte received by spi_slave, stable while spi_done is high
//   spi_ten, spi_tdata, spi_mlb   transmit controls back to spi_slave
//   loc_addr, loc_rdata           fabric combinational read port
//   wr_strobe, wr_addr, wr_data   one-cycle notification of each committed write
//   frame_active    high while an accepted frame is in progress
//   addr_err        sticky per frame: command had nonzero bits above the address field
module spi_reg_sequencer #(
  parameter int          ADDR_W    = 4,
  parameter int          MSB_FIRST = 1,
  parameter logic [7:0]  STATUS    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              spi_done,
  input  logic [7:0]        spi_rdata,
  output logic              spi_ten,
  output logic [7:0]        spi_tdata,
  output logic              spi_mlb,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_active,
  output logic              addr_err
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [7:0] HI_MASK = 8'h7F & ~8'((1 << ADDR_W) - 1);
  localparam logic       MLB     = (MSB_FIRST != 0);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, SKIP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [7:0]        tdata_n;
  logic              ten_n, active_n, aerr_n, we;

  logic [7:0] regs [DEPTH];

  // Synchronizers plus one edge-detect stage each: an input edge acts on the
  // third clk edge after it arrives.
  logic ss_s1, ss_s2, ss_d;
  logic dn_s1, dn_s2, dn_d;
  logic [1:0] fill;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_s1 <= 1'b1;
      ss_s2 <= 1'b1;
      ss_d  <= 1'b1;
      dn_s1 <= 1'b0;
      dn_s2 <= 1'b0;
      dn_d  <= 1'b0;
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      ss_s1 <= ss_n;
      ss_s2 <= ss_s1;
      ss_d  <= ss_s2;
      dn_s1 <= spi_done;
      dn_s2 <= dn_s1;
      dn_d  <= dn_s2;
      if (fill != 2'd2) fill <= fill + 2'd1;
      // ss_s2 only reflects the pin once both stages have reloaded after reset,
      // so a frame already in progress at release can never arm us.
      if (fill == 2'd2 && ss_s2) armed <= 1'b1;
    end
  end

  logic ss_fall, ss_rise, done_rise, cmd_bad;
  assign ss_fall   = armed & ss_d & ~ss_s2;
  assign ss_rise   = ~ss_d & ss_s2;
  assign done_rise = dn_s2 & ~dn_d;
  assign cmd_bad   = |(spi_rdata & HI_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      spi_tdata    <= 8'h00;
      spi_ten      <= 1'b0;
      frame_active <= 1'b0;
      addr_err     <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'h00;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      spi_tdata    <= tdata_n;
      spi_ten      <= ten_n;
      frame_active <= active_n;
      addr_err     <= aerr_n;
      wr_strobe    <= we;
      if (we) begin
        wr_addr <= ptr;
        wr_data <= spi_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[ptr] <= spi_rdata;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    tdata_n  = spi_tdata;
    ten_n    = spi_ten;
    active_n = frame_active;
    aerr_n   = addr_err;
    we       = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n  = CMD;
          active_n = 1'b1;
          ten_n    = 1'b1;
          tdata_n  = STATUS;
          aerr_n   = 1'b0;
        end
      end
      CMD: begin
        if (done_rise) begin
          if (cmd_bad) begin
            state_n = SKIP;
            aerr_n  = 1'b1;
            tdata_n = 8'hFF;
          end else if (spi_rdata[7]) begin
            state_n = WRITE;
            ptr_n   = spi_rdata[ADDR_W-1:0];
          end else begin
            state_n = READ;
            tdata_n = regs[spi_rdata[ADDR_W-1:0]];
            ptr_n   = spi_rdata[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
      end
      WRITE: begin
        if (done_rise) begin
          we      = 1'b1;
          ptr_n   = ptr + ADDR_W'(1);
          tdata_n = 8'h00;
        end
      end
      READ: begin
        if (done_rise) begin
          tdata_n = regs[ptr];
          ptr_n   = ptr + ADDR_W'(1);
        end
      end
      SKIP: begin
        tdata_n = 8'hFF;
      end
      default: state_n = IDLE;
    endcase
    // Frame end overrides the state only; a byte finishing in the same cycle
    // has already been handled above, so its write still commits.
    if (ss_rise && state != IDLE) begin
      state_n  = IDLE;
      ten_n    = 1'b0;
      active_n = 1'b0;
    end
  end

  assign loc_rdata = regs[loc_addr];
  assign spi_mlb   = MLB;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb/tb_spi_reg_sequencer.sv - directed scoreboard bench for spi_reg_sequencer
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       spi_done;
  logic [7:0] spi_rdata;
  logic       spi_ten;
  logic [7:0] spi_tdata;
  logic       spi_mlb;
  logic [3:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_active;
  logic       addr_err;

  spi_reg_sequencer #(.ADDR_W(4), .MSB_FIRST(1), .STATUS(8'hA5)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .spi_ten(spi_ten), .spi_tdata(spi_tdata), .spi_mlb(spi_mlb),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_active(frame_active), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_q[$];
  logic [11:0] wq[$];
  logic [7:0]  mdl[16];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      chk("wr_expected", 12'(wq.size() > 0), 12'd1);
      if (wq.size() > 0) chk("wr_addr_data", {wr_addr, wr_data}, wq.pop_front());
    end
  end

  task automatic frame_start();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  // One byte as spi_slave would see it: what is on spi_tdata now is what the
  // master receives during this byte.
  task automatic xfer(input logic [7:0] rx, input bit look, input string tag);
    @(negedge clk);
    if (look) chk(tag, {4'h0, spi_tdata}, {4'h0, tx_q.pop_front()});
    spi_rdata = rx;
    spi_done  = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    spi_done  = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic peek(input logic [3:0] a, input string tag);
    @(negedge clk);
    loc_addr = a;
    #1;
    chk(tag, {4'h0, loc_rdata}, {4'h0, mdl[a]});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    rst = 1'b1; ss_n = 1'b0; spi_done = 1'b0; spi_rdata = 8'h00; loc_addr = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ten",    {11'h0, spi_ten},      12'h0);
    chk("rst_tdata",  {4'h0, spi_tdata},     12'h000);
    chk("rst_mlb",    {11'h0, spi_mlb},      12'h1);
    chk("rst_strobe", {11'h0, wr_strobe},    12'h0);
    chk("rst_active", {11'h0, frame_active}, 12'h0);
    chk("rst_aerr",   {11'h0, addr_err},     12'h0);
    chk("rst_wr",     {wr_addr, wr_data},    12'h000);
    rst = 1'b0;

    // 1: ss low at reset release -> whole frame ignored
    xfer(8'h81, 1'b0, "");
    chk("t1_active", {11'h0, frame_active}, 12'h0);
    xfer(8'h55, 1'b0, "");
    frame_end();
    peek(4'h1, "t1_reg1");

    // 2: write 0x11,0x22 starting at 3
    frame_start();
    chk("t2_active", {11'h0, frame_active}, 12'h1);
    chk("t2_ten",    {11'h0, spi_ten},      12'h1);
    tx_q.push_back(8'hA5);
    xfer(8'h83, 1'b1, "t2_status");
    wq.push_back({4'h3, 8'h11}); mdl[3] = 8'h11;
    xfer(8'h11, 1'b0, "");
    wq.push_back({4'h4, 8'h22}); mdl[4] = 8'h22;
    tx_q.push_back(8'h00);
    xfer(8'h22, 1'b1, "t2_tx_after_data");
    frame_end();
    chk("t2_active_end", {11'h0, frame_active}, 12'h0);
    chk("t2_ten_end",    {11'h0, spi_ten},      12'h0);
    peek(4'h3, "t2_reg3");
    peek(4'h4, "t2_reg4");

    // 3: preload reg[2]=0x7C, then read from 2
    frame_start();
    xfer(8'h82, 1'b0, "");
    wq.push_back({4'h2, 8'h7C}); mdl[2] = 8'h7C;
    xfer(8'h7C, 1'b0, "");
    frame_end();
    frame_start();
    tx_q.push_back(8'hA5);
    xfer(8'h02, 1'b1, "t3_status");
    tx_q.push_back(mdl[2]);
    xfer(8'h00, 1'b1, "t3_rd_reg2");
    tx_q.push_back(mdl[3]);
    xfer(8'h00, 1'b1, "t3_rd_reg3");
    chk("t3_mlb", {11'h0, spi_mlb}, 12'h1);
    frame_end();

    // 4: write across the top of the register file
    frame_start();
    xfer(8'h8F, 1'b0, "");
    wq.push_back({4'hF, 8'hAA}); mdl[15] = 8'hAA;
    xfer(8'hAA, 1'b0, "");
    wq.push_back({4'h0, 8'hBB}); mdl[0] = 8'hBB;
    xfer(8'hBB, 1'b0, "");
    frame_end();
    peek(4'hF, "t4_reg15");
    peek(4'h0, "t4_reg0_wrap");

    // 5: out-of-range command
    frame_start();
    tx_q.push_back(8'hA5);
    xfer(8'h90, 1'b1, "t5_status");
    chk("t5_aerr", {11'h0, addr_err}, 12'h1);
    tx_q.push_back(8'hFF);
    xfer(8'h12, 1'b1, "t5_ff0");
    tx_q.push_back(8'hFF);
    xfer(8'h34, 1'b1, "t5_ff1");
    frame_end();
    chk("t5_aerr_held", {11'h0, addr_err}, 12'h1);
    peek(4'h0, "t5_reg0_kept");
    frame_start();
    chk("t5_aerr_clear", {11'h0, addr_err}, 12'h0);
    xfer(8'h01, 1'b0, "");
    frame_end();

    // 6: reset in the middle of a write frame
    frame_start();
    xfer(8'h85, 1'b0, "");
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    chk("t6_ten",    {11'h0, spi_ten},      12'h0);
    chk("t6_tdata",  {4'h0, spi_tdata},     12'h000);
    chk("t6_active", {11'h0, frame_active}, 12'h0);
    chk("t6_wr",     {wr_addr, wr_data},    12'h000);
    @(negedge clk);
    rst = 1'b0;
    xfer(8'h66, 1'b0, "");
    chk("t6_active_ignored", {11'h0, frame_active}, 12'h0);
    frame_end();
    peek(4'h5, "t6_reg5_nowrite");
    peek(4'h3, "t6_reg3_cleared");
    frame_start();
    xfer(8'h85, 1'b0, "");
    wq.push_back({4'h5, 8'h66}); mdl[5] = 8'h66;
    xfer(8'h66, 1'b0, "");
    frame_end();
    peek(4'h5, "t6_reg5_new");

    chk("wq_drained", 12'(wq.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
